mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Fifth pipeline stage: sits between EX and WB. It latches the EX result bundle, performs the load/store access on the data SRAM over a split request/response handshake, and packs the register-writeback bundle consumed by WB. Byte-lane extraction and sign extension stay in WB; this stage forwards the raw read word plus lane enables.

## Interface
- No parameters; all widths fixed.
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- EX_to_MEM_valid  in  1  EX holds a valid instruction
- MEM_allow_in  out  1  stage can accept from EX this cycle
- EX_to_MEM_bus  in  106  {mem_re[105], mem_we[104], mem_byte[103], rf_we[102], rsvd[101], rf_waddr[100:96], store_data[95:64], alu_result[63:32], pc[31:0]}
- MEM_to_WB_valid  out  1  bundle valid toward WB
- WB_allow_in  in  1  WB accepts this cycle
- MEM_to_WB_bus  out  108  {rf_we, sel_rf_w_data(=mem_re), sel_data_ram_wd(=mem_re&mem_byte), data_ram_b_en[3:0], rdata[31:0], rf_waddr[4:0], alu_result[31:0], pc[31:0]}
- MEM_to_ID_bus  out  39  {fwd_en, fwd_ready, rf_waddr[4:0], alu_result[31:0]} for hazard/bypass in ID
- data_sram_req  out  1  access request
- data_sram_wr  out  1  1 = store
- data_sram_wstrb  out  4  store byte strobes
- data_sram_addr  out  32  = alu_result
- data_sram_wdata  out  32  store data
- data_sram_addr_ok  in  1  request accepted
- data_sram_data_ok  in  1  read data valid / write completed
- data_sram_rdata  in  32  read word

## Operation
- Handshake: MEM_allow_in = ~MEM_valid | (ready_go & WB_allow_in); MEM_to_WB_valid = MEM_valid & ready_go. Bundle latched when EX_to_MEM_valid & MEM_allow_in; MEM_valid set/cleared accordingly.
- mem op = mem_re | mem_we (both set is illegal; treat as load). Non-mem instructions: ready_go = 1 in the latch-following cycle, no SRAM traffic.
- FSM states IDLE, REQ, WAIT, DONE:
  - latch of mem op -> REQ; latch of non-mem -> IDLE.
  - REQ: data_sram_req=1; addr_ok & data_ok same cycle -> DONE; addr_ok alone -> WAIT.
  - WAIT: req=0; data_ok -> DONE.
  - DONE: ready_go=1; on handoff (ready_go & WB_allow_in) go to IDLE, or directly to REQ if a new mem op latches in the same edge.
- rdata register captured on data_ok (loads only); held stable through DONE while WB stalls.
- Lane enables: byte -> 4'b0001 << alu_result[1:0]; word -> 4'b1111. data_ram_b_en carries this for loads; wstrb carries it for stores (0 when not storing).
- wdata: byte store -> {4{store_data[7:0]}}; word store -> store_data. Word addresses must be aligned; low bits passed unmodified.
- MEM_to_ID: fwd_en = MEM_valid & rf_we; fwd_ready = ~mem_re | (state==DONE) (a load's value is not bypassable before then).
- data_ok arriving in IDLE/DONE is a protocol error and is ignored.

## Timing
- Reset (async): MEM_valid=0, FSM=IDLE, req=0, bundle and rdata registers=0, all outputs 0 (MEM_allow_in=1).
- Reset mid-transaction: outstanding access abandoned, no retry; stage empty after release.
- Non-mem latency: latched at edge N, handed to WB at edge N+1 (1 cycle/instr at full throughput).
- Load/store min latency: latched edge N, req in cycle N+1 with addr_ok, data_ok in N+2, DONE in N+3, handed to WB at edge N+3 end. Same-cycle addr_ok+data_ok saves one cycle.
- req held with stable addr/wr/wstrb/wdata until addr_ok; never deasserted early.
- WB stall in DONE: stage holds bundle and rdata, MEM_allow_in=0, no new request.

## Test plan
- Reset asserted mid-REQ with req=1 -> req drops asynchronously, MEM_to_WB_valid=0, MEM_allow_in=1.
- Back-to-back 4 ALU ops (rf_we=1, waddr=1..4) with WB_allow_in=1 -> four WB bundles on consecutive cycles, sel_rf_w_data=0.
- Word load addr 0x1000, addr_ok after 2 cycles, data_ok 3 cycles later with 0xDEADBEEF -> one bundle, rdata=0xDEADBEEF, b_en=1111, sel_data_ram_wd=0; fwd_ready=0 until DONE.
- Byte store addr 0x1003, store_data 0x000000A5 -> wstrb=1000, wdata=0xA5A5A5A5, wr=1, bundle rf_we=0.
- Byte load addr 0x1002 with addr_ok&data_ok same cycle, WB_allow_in low 3 cycles -> b_en=0100, sel_data_ram_wd=1, bundle/rdata stable across stall, no second req.
- Load followed by ALU op in EX -> ALU op latched on the load's handoff edge, reaches WB exactly one cycle after the load.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: EX->MEM handshake, MEM->WB/ID bundles and data SRAM request/response
//   slave  : used by the stage (consumes EX bundle and SRAM responses, drives WB/ID/SRAM request)
//   master : used by the surrounding pipeline/SRAM model (opposite directions)
interface mem_access_stage_if;
  logic         EX_to_MEM_valid;
  logic         MEM_allow_in;
  logic [105:0] EX_to_MEM_bus;
  logic         MEM_to_WB_valid;
  logic         WB_allow_in;
  logic [107:0] MEM_to_WB_bus;
  logic [38:0]  MEM_to_ID_bus;
  logic         data_sram_req;
  logic         data_sram_wr;
  logic [3:0]   data_sram_wstrb;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         data_sram_addr_ok;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  modport slave (
    input  EX_to_MEM_valid, EX_to_MEM_bus, WB_allow_in,
           data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    output MEM_allow_in, MEM_to_WB_valid, MEM_to_WB_bus, MEM_to_ID_bus,
           data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata
  );
  modport master (
    output EX_to_MEM_valid, EX_to_MEM_bus, WB_allow_in,
           data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    input  MEM_allow_in, MEM_to_WB_valid, MEM_to_WB_bus, MEM_to_ID_bus,
           data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage, latches EX bundle, runs the data SRAM access, feeds WB and ID bypass
//   clk, reset : clock and asynchronous active-high reset
//   p (slave)  : EX_to_MEM valid/allow/bus, MEM_to_WB valid/allow/bus, MEM_to_ID bus, data SRAM req/resp
module mem_access_stage (
  input  logic clk,
  input  logic reset,
  mem_access_stage_if.slave p
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic         mem_valid_q, mem_valid_d;
  logic [105:0] ex_q, ex_d;
  logic [31:0]  rdata_q, rdata_d;
  logic         mem_re, mem_we, mem_byte, rf_we, unused_rsvd;
  logic [4:0]   rf_waddr;
  logic [31:0]  store_data, alu_result, pc;
  logic         mem_op, ready_go, allow_in, latch, new_op, data_done, store;
  logic [3:0]   lane;
  assign {mem_re, mem_we, mem_byte, rf_we, unused_rsvd, rf_waddr, store_data, alu_result, pc} = ex_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      ex_q        <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      ex_q        <= ex_d;
      rdata_q     <= rdata_d;
    end
  always_comb begin
    mem_op      = mem_re | mem_we;
    // a latched non-mem op sits in IDLE and is ready at once; mem ops are ready only in DONE
    ready_go    = state_q == IDLE ? ~mem_op : state_q == DONE;
    allow_in    = ~mem_valid_q | (ready_go & p.WB_allow_in);
    latch       = p.EX_to_MEM_valid & allow_in;
    new_op      = p.EX_to_MEM_bus[105] | p.EX_to_MEM_bus[104];
    // data_ok is only meaningful once the request has been accepted
    data_done   = ((state_q == REQ & p.data_sram_addr_ok) | state_q == WAIT) & p.data_sram_data_ok;
    mem_valid_d = allow_in ? p.EX_to_MEM_valid : mem_valid_q;
    ex_d        = latch ? p.EX_to_MEM_bus : ex_q;
    rdata_d     = latch ? 32'h0 : (data_done & mem_re) ? p.data_sram_rdata : rdata_q;
    state_d     = state_q == REQ  ? (p.data_sram_addr_ok ? (p.data_sram_data_ok ? DONE : WAIT) : REQ) :
                  state_q == WAIT ? (p.data_sram_data_ok ? DONE : WAIT) :
                  allow_in        ? ((latch & new_op) ? REQ : IDLE) : state_q;
  end
  always_comb begin
    store             = mem_we & ~mem_re;
    lane              = mem_byte ? 4'b0001 << alu_result[1:0] : 4'b1111;
    p.MEM_allow_in    = allow_in;
    p.MEM_to_WB_valid = mem_valid_q & ready_go;
    p.data_sram_req   = state_q == REQ;
    p.data_sram_wr    = store;
    p.data_sram_wstrb = store ? lane : 4'b0000;
    p.data_sram_addr  = alu_result;
    p.data_sram_wdata = mem_byte ? {4{store_data[7:0]}} : store_data;
    p.MEM_to_WB_bus   = {rf_we, mem_re, mem_re & mem_byte, mem_re ? lane : 4'b0000,
                         rdata_q, rf_waddr, alu_result, pc};
    p.MEM_to_ID_bus   = {mem_valid_q & rf_we, mem_valid_q & (~mem_re | state_q == DONE),
                         rf_waddr, alu_result};
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: table-driven and scoreboard bench for mem_access_stage
module tb_mem_access_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mem_access_stage_if ifc();
  mem_access_stage dut (.clk(clk), .reset(reset), .p(ifc.slave));
  typedef struct {
    logic re, we, bt, rf_we;
    logic [4:0] waddr;
    logic [31:0] sd, alu, pc, rd;
    int aok, dok;
    logic [3:0] ben, wstrb;
    logic [31:0] wdata;
    logic selwd;
    logic [31:0] exp_rd;
  } vec_t;
  typedef struct {
    logic [31:0] addr, wdata, rd;
    logic wr;
    logic [3:0] wstrb;
    int aok, dok;
  } sreq_t;
  logic [107:0] wb_q[$];
  sreq_t sram_q[$];
  int hand_cyc[$];
  int total = 0, bad = 0, cyc = 0, nreq = 0;
  int wcnt = 0, pend = 0;
  logic [31:0] cur_rd;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [107:0] act, logic [107:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  function automatic vec_t mk(logic re, logic we, logic bt, logic rf_we, logic [4:0] waddr,
                              logic [31:0] sd, logic [31:0] alu, logic [31:0] pc, logic [31:0] rd,
                              int aok, int dok, logic [3:0] ben, logic [3:0] wstrb,
                              logic [31:0] wdata, logic selwd, logic [31:0] exp_rd);
    vec_t v;
    v.re = re; v.we = we; v.bt = bt; v.rf_we = rf_we; v.waddr = waddr;
    v.sd = sd; v.alu = alu; v.pc = pc; v.rd = rd; v.aok = aok; v.dok = dok;
    v.ben = ben; v.wstrb = wstrb; v.wdata = wdata; v.selwd = selwd; v.exp_rd = exp_rd;
    return v;
  endfunction
  function automatic logic [107:0] wb_exp(vec_t v);
    return {v.rf_we, v.re, v.selwd, v.ben, v.exp_rd, v.waddr, v.alu, v.pc};
  endfunction
  task automatic send(vec_t v);
    int n = 0;
    sreq_t s;
    ifc.EX_to_MEM_valid = 1'b1;
    ifc.EX_to_MEM_bus = {v.re, v.we, v.bt, v.rf_we, 1'b0, v.waddr, v.sd, v.alu, v.pc};
    wb_q.push_back(wb_exp(v));
    if (v.re | v.we) begin
      s.addr = v.alu; s.wdata = v.wdata; s.rd = v.rd; s.wr = v.we & ~v.re;
      s.wstrb = v.wstrb; s.aok = v.aok; s.dok = v.dok;
      sram_q.push_back(s);
    end
    do begin @(negedge clk); n++; end while (!ifc.MEM_allow_in && n < 100);
    chk("send_accept", ifc.MEM_allow_in, 1);
    @(posedge clk); #1;
    ifc.EX_to_MEM_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (wb_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain", wb_q.size(), 0);
    @(posedge clk); #1;
  endtask
  always @(negedge clk)
    if (!reset && ifc.MEM_to_WB_valid && ifc.WB_allow_in) begin
      hand_cyc.push_back(cyc);
      if (wb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL wb_unexpected: got %h expected none", ifc.MEM_to_WB_bus);
      end else chk("wb_bundle", ifc.MEM_to_WB_bus, wb_q.pop_front());
    end
  initial begin
    sreq_t cur;
    ifc.data_sram_addr_ok = 1'b0;
    ifc.data_sram_data_ok = 1'b0;
    ifc.data_sram_rdata = 32'h0BAD0BAD;
    forever begin
      @(posedge clk); #1;
      ifc.data_sram_addr_ok = 1'b0;
      ifc.data_sram_data_ok = 1'b0;
      ifc.data_sram_rdata = 32'h0BAD0BAD;
      if (reset) begin
        wcnt = 0; pend = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin ifc.data_sram_data_ok = 1'b1; ifc.data_sram_rdata = cur_rd; end
      end else if (ifc.data_sram_req) begin
        if (sram_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sram_unexpected_req: got req=1 expected 0 addr=%h", ifc.data_sram_addr);
        end else begin
          cur = sram_q[0];
          chk("sram_addr", ifc.data_sram_addr, cur.addr);
          chk("sram_wr", ifc.data_sram_wr, cur.wr);
          chk("sram_wstrb", ifc.data_sram_wstrb, cur.wstrb);
          if (cur.wr) chk("sram_wdata", ifc.data_sram_wdata, cur.wdata);
          if (wcnt < cur.aok) wcnt++;
          else begin
            ifc.data_sram_addr_ok = 1'b1;
            wcnt = 0;
            nreq++;
            void'(sram_q.pop_front());
            if (cur.dok == 0) begin ifc.data_sram_data_ok = 1'b1; ifc.data_sram_rdata = cur.rd; end
            else begin pend = cur.dok; cur_rd = cur.rd; end
          end
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    vec_t tbl[10];
    vec_t v;
    int r0;
    for (int i = 0; i < 4; i++)
      tbl[i] = mk(0, 0, 0, 1, 5'(i + 1), 32'h0, 32'h100 * (i + 1) + 7, 32'h200 + 4 * i, 32'h0,
                  0, 0, 4'h0, 4'h0, 32'h0, 0, 32'h0);
    tbl[4] = mk(0, 1, 1, 0, 5'd0, 32'h000000A5, 32'h1003, 32'h300, 32'hBAADF00D, 1, 1,
                4'h0, 4'b1000, 32'hA5A5A5A5, 0, 32'h0);
    tbl[5] = mk(0, 1, 0, 0, 5'd0, 32'h12345678, 32'h2004, 32'h304, 32'hBAADF00D, 0, 0,
                4'h0, 4'b1111, 32'h12345678, 0, 32'h0);
    tbl[6] = mk(1, 0, 1, 1, 5'd7, 32'h0, 32'h2001, 32'h308, 32'h11223344, 0, 2,
                4'b0010, 4'h0, 32'h0, 1, 32'h11223344);
    tbl[7] = mk(1, 0, 0, 1, 5'd8, 32'h0, 32'h3000, 32'h30C, 32'hCAFEF00D, 1, 0,
                4'b1111, 4'h0, 32'h0, 0, 32'hCAFEF00D);
    tbl[8] = mk(0, 1, 1, 0, 5'd0, 32'hFFFFFF3C, 32'h2000, 32'h310, 32'hBAADF00D, 0, 1,
                4'h0, 4'b0001, 32'h3C3C3C3C, 0, 32'h0);
    tbl[9] = mk(1, 1, 0, 1, 5'd9, 32'h77, 32'h40, 32'h314, 32'h55AA55AA, 0, 0,
                4'b1111, 4'h0, 32'h0, 0, 32'h55AA55AA);
    ifc.EX_to_MEM_valid = 1'b0;
    ifc.EX_to_MEM_bus = '0;
    ifc.WB_allow_in = 1'b1;
    #2;
    chk("rst_allow_in", ifc.MEM_allow_in, 1);
    chk("rst_wb_valid", ifc.MEM_to_WB_valid, 0);
    chk("rst_req", ifc.data_sram_req, 0);
    chk("rst_wb_bus", ifc.MEM_to_WB_bus, 0);
    chk("rst_id_bus", ifc.MEM_to_ID_bus, 0);
    chk("rst_sram_out", {ifc.data_sram_wr, ifc.data_sram_wstrb, ifc.data_sram_addr, ifc.data_sram_wdata}, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    hand_cyc.delete();
    for (int i = 0; i < 10; i++) send(tbl[i]);
    drain();
    chk("table_handoffs", hand_cyc.size(), 10);
    if (hand_cyc.size() >= 4)
      for (int i = 1; i < 4; i++) chk("alu_back_to_back", hand_cyc[i] - hand_cyc[i - 1], 1);
    v = mk(1, 0, 0, 1, 5'd5, 32'h0, 32'h1000, 32'h400, 32'hDEADBEEF, 2, 3,
           4'b1111, 4'h0, 32'h0, 0, 32'hDEADBEEF);
    send(v);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("load_fwd_ready", ifc.MEM_to_ID_bus[37], k == 7);
      chk("load_fwd_en", ifc.MEM_to_ID_bus[38], 1);
      chk("load_wb_valid", ifc.MEM_to_WB_valid, k == 7);
    end
    drain();
    ifc.WB_allow_in = 1'b0;
    r0 = nreq;
    v = mk(1, 0, 1, 1, 5'd6, 32'h0, 32'h1002, 32'h404, 32'h99887766, 0, 0,
           4'b0100, 4'h0, 32'h0, 1, 32'h99887766);
    send(v);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_wb_valid", ifc.MEM_to_WB_valid, 1);
      chk("stall_allow_in", ifc.MEM_allow_in, 0);
      chk("stall_req", ifc.data_sram_req, 0);
      chk("stall_bundle", ifc.MEM_to_WB_bus, wb_exp(v));
    end
    @(posedge clk); #1;
    ifc.WB_allow_in = 1'b1;
    drain();
    chk("stall_one_req", nreq - r0, 1);
    hand_cyc.delete();
    send(mk(1, 0, 0, 1, 5'd10, 32'h0, 32'h5000, 32'h500, 32'h01020304, 0, 1,
            4'b1111, 4'h0, 32'h0, 0, 32'h01020304));
    send(mk(0, 0, 0, 1, 5'd11, 32'h0, 32'h00000042, 32'h504, 32'h0, 0, 0,
            4'h0, 4'h0, 32'h0, 0, 32'h0));
    drain();
    chk("load_alu_handoffs", hand_cyc.size(), 2);
    if (hand_cyc.size() == 2) chk("alu_after_load", hand_cyc[1] - hand_cyc[0], 1);
    send(mk(1, 0, 0, 1, 5'd12, 32'h0, 32'h6000, 32'h600, 32'h0, 50, 0,
            4'b1111, 4'h0, 32'h0, 0, 32'h0));
    @(negedge clk);
    chk("pre_reset_req", ifc.data_sram_req, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_req", ifc.data_sram_req, 0);
    chk("async_reset_wb_valid", ifc.MEM_to_WB_valid, 0);
    chk("async_reset_allow_in", ifc.MEM_allow_in, 1);
    wb_q.delete();
    sram_q.delete();
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_reset_req", ifc.data_sram_req, 0);
      chk("post_reset_wb_valid", ifc.MEM_to_WB_valid, 0);
      chk("post_reset_allow_in", ifc.MEM_allow_in, 1);
    end
    chk("sram_queue_empty", sram_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
